// File: rtl/hwacc_region_pmu.sv
// rtl/hwacc_region_pmu.sv - per-region clock gating FSMs with wake/grant handshake
// and lossless per-line event merging into saturating pending counters.
module hwacc_region_pmu #(
    parameter int NB_CORES    = 2,
    parameter int NB_HWACC    = 3,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int EVT_CNT_W   = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           test_mode,
    input  logic [NB_HWACC-1:0]            region_busy_i,
    input  logic [NB_HWACC*NB_CORES*2-1:0] region_evt_i,
    input  logic [NB_HWACC-1:0]            cfg_req_i,
    output logic [NB_HWACC-1:0]            cfg_gnt_o,
    output logic [NB_HWACC-1:0]            region_clk_en_o,
    output logic [NB_CORES*2-1:0]          evt_o,
    output logic [NB_CORES*2-1:0]          evt_ovf_o,
    input  logic                           evt_ovf_clr_i,
    output logic                           busy_o
);

    localparam int E      = NB_CORES * 2;
    localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int CW     = EVT_CNT_W + 2;

    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [CW-1:0]     PEND_MAX  = CW'((1 << EVT_CNT_W) - 1);

    typedef enum logic [1:0] {
        GATED = 2'd0,
        WAKE  = 2'd1,
        RUN   = 2'd2
    } state_e;

    state_e                state_q    [NB_HWACC];
    state_e                state_d    [NB_HWACC];
    logic [WAKE_W-1:0]     wake_cnt_q [NB_HWACC];
    logic [WAKE_W-1:0]     wake_cnt_d [NB_HWACC];
    logic [IDLE_W-1:0]     idle_cnt_q [NB_HWACC];
    logic [IDLE_W-1:0]     idle_cnt_d [NB_HWACC];
    logic [EVT_CNT_W-1:0]  pend_q     [E];
    logic [EVT_CNT_W-1:0]  pend_d     [E];
    logic [CW-1:0]         inc        [E];
    logic [CW-1:0]         nxt        [E];
    logic [E-1:0]          ovf_q, ovf_d;
    logic                  busy_q, busy_d;
    logic                  any_wake;
    logic                  any_pend_d;

    always_comb begin
        for (int r = 0; r < NB_HWACC; r++) begin
            state_d[r]    = state_q[r];
            wake_cnt_d[r] = wake_cnt_q[r];
            idle_cnt_d[r] = idle_cnt_q[r];
            case (state_q[r])
                GATED: begin
                    if (cfg_req_i[r] || region_busy_i[r]) begin
                        state_d[r]    = WAKE;
                        wake_cnt_d[r] = '0;
                    end
                end
                WAKE: begin
                    if (wake_cnt_q[r] == WAKE_LAST) begin
                        state_d[r]    = RUN;
                        idle_cnt_d[r] = '0;
                    end else begin
                        wake_cnt_d[r] = wake_cnt_q[r] + 1'b1;
                    end
                end
                RUN: begin
                    if (cfg_req_i[r] || region_busy_i[r]) begin
                        idle_cnt_d[r] = '0;
                    end else if (idle_cnt_q[r] == IDLE_LAST) begin
                        state_d[r] = GATED;
                    end else begin
                        idle_cnt_d[r] = idle_cnt_q[r] + 1'b1;
                    end
                end
                default: state_d[r] = GATED;
            endcase
            // DFT parks every region in RUN so it resumes with a full idle countdown.
            if (test_mode) begin
                state_d[r]    = RUN;
                idle_cnt_d[r] = '0;
            end
        end
    end

    always_comb begin
        any_wake = 1'b0;
        for (int r = 0; r < NB_HWACC; r++) begin
            region_clk_en_o[r] = test_mode || (state_q[r] != GATED);
            cfg_gnt_o[r]       = cfg_req_i[r] && (test_mode || (state_q[r] == RUN));
            if (state_q[r] == WAKE) any_wake = 1'b1;
        end
    end

    always_comb begin
        ovf_d      = ovf_q & ~{E{evt_ovf_clr_i}};
        any_pend_d = 1'b0;
        for (int e = 0; e < E; e++) begin
            inc[e] = '0;
            for (int r = 0; r < NB_HWACC; r++) begin
                inc[e] = inc[e] + CW'(region_evt_i[r*E+e]);
            end
            nxt[e] = CW'(pend_q[e]) + inc[e] - CW'(pend_q[e] != '0);
            // Saturate rather than wrap; the sticky flag records the loss.
            if (nxt[e] > PEND_MAX) begin
                pend_d[e] = EVT_CNT_W'(PEND_MAX);
                ovf_d[e]  = 1'b1;
            end else begin
                pend_d[e] = nxt[e][EVT_CNT_W-1:0];
            end
            if (pend_d[e] != '0) any_pend_d = 1'b1;
        end
        busy_d = (|region_busy_i) || any_wake || any_pend_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NB_HWACC; r++) begin
                state_q[r]    <= GATED;
                wake_cnt_q[r] <= '0;
                idle_cnt_q[r] <= '0;
            end
            for (int e = 0; e < E; e++) begin
                pend_q[e] <= '0;
            end
            ovf_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            for (int r = 0; r < NB_HWACC; r++) begin
                state_q[r]    <= state_d[r];
                wake_cnt_q[r] <= wake_cnt_d[r];
                idle_cnt_q[r] <= idle_cnt_d[r];
            end
            for (int e = 0; e < E; e++) begin
                pend_q[e] <= pend_d[e];
            end
            ovf_q  <= ovf_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        for (int e = 0; e < E; e++) begin
            evt_o[e] = (pend_q[e] != '0);
        end
    end

    assign evt_ovf_o = ovf_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_hwacc_region_pmu.sv
// tb/tb_hwacc_region_pmu.sv - directed checks of gating, wake handshake, event merge,
// saturation, test_mode and mid-operation reset.
module tb_hwacc_region_pmu;

    logic        clk = 1'b0;
    logic        rst;
    logic        test_mode;
    logic [2:0]  region_busy_i;
    logic [11:0] region_evt_i;
    logic [2:0]  cfg_req_i;
    logic [2:0]  cfg_gnt_o;
    logic [2:0]  region_clk_en_o;
    logic [3:0]  evt_o;
    logic [3:0]  evt_ovf_o;
    logic        evt_ovf_clr_i;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    hwacc_region_pmu #(
        .NB_CORES(2), .NB_HWACC(3), .IDLE_CYCLES(16), .WAKE_CYCLES(2), .EVT_CNT_W(3)
    ) dut (
        .clk(clk), .rst(rst), .test_mode(test_mode),
        .region_busy_i(region_busy_i), .region_evt_i(region_evt_i),
        .cfg_req_i(cfg_req_i), .cfg_gnt_o(cfg_gnt_o),
        .region_clk_en_o(region_clk_en_o), .evt_o(evt_o),
        .evt_ovf_o(evt_ovf_o), .evt_ovf_clr_i(evt_ovf_clr_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst           = 1'b1;
        test_mode     = 1'b0;
        region_busy_i = '0;
        region_evt_i  = '0;
        cfg_req_i     = '0;
        evt_ovf_clr_i = 1'b0;
        ticks(3);
        chk("rst_clk_en", 32'(region_clk_en_o), 32'h0);
        chk("rst_evt", 32'(evt_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        rst = 1'b0;
        ticks(20);
        chk("idle_clk_en", 32'(region_clk_en_o), 32'h0);
        chk("idle_gnt", 32'(cfg_gnt_o), 32'h0);
        chk("idle_ovf", 32'(evt_ovf_o), 32'h0);
        chk("idle_busy", 32'(busy_o), 32'h0);

        // Wake handshake on region 1, then idle gating.
        cfg_req_i = 3'b010;
        #1;
        chk("wake_t0_clk_en", 32'(region_clk_en_o), 32'h0);
        chk("wake_t0_gnt", 32'(cfg_gnt_o), 32'h0);
        tick();
        chk("wake_t1_clk_en", 32'(region_clk_en_o), 32'h2);
        chk("wake_t1_gnt", 32'(cfg_gnt_o), 32'h0);
        tick();
        chk("wake_t2_gnt", 32'(cfg_gnt_o), 32'h0);
        chk("wake_t2_busy", 32'(busy_o), 32'h1);
        tick();
        chk("wake_t3_gnt", 32'(cfg_gnt_o), 32'h2);
        chk("wake_t3_clk_en", 32'(region_clk_en_o), 32'h2);
        tick();
        cfg_req_i = 3'b000;
        #1;
        chk("run_gnt_drop", 32'(cfg_gnt_o), 32'h0);
        chk("run_busy_low", 32'(busy_o), 32'h0);
        ticks(15);
        chk("r1_last_idle", 32'(region_clk_en_o), 32'h2);
        tick();
        chk("r1_gated", 32'(region_clk_en_o), 32'h0);

        // Region 0 busy, idle countdown restarted by a single request.
        region_busy_i = 3'b001;
        ticks(5);
        region_busy_i = 3'b000;
        ticks(5);
        cfg_req_i = 3'b001;
        #1;
        chk("r0_restart_gnt", 32'(cfg_gnt_o), 32'h1);
        tick();
        cfg_req_i = 3'b000;
        ticks(10);
        chk("r0_no_early_gate", 32'(region_clk_en_o), 32'h1);
        ticks(5);
        chk("r0_last_idle", 32'(region_clk_en_o), 32'h1);
        tick();
        chk("r0_gated", 32'(region_clk_en_o), 32'h0);

        // Three coincident pulses on line 0.
        tick();
        region_evt_i = 12'h111;
        #1;
        chk("coin_t0_evt", 32'(evt_o), 32'h0);
        chk("coin_t0_busy", 32'(busy_o), 32'h0);
        tick();
        region_evt_i = 12'h000;
        chk("coin_t1_evt", 32'(evt_o), 32'h1);
        chk("coin_t1_busy", 32'(busy_o), 32'h1);
        tick();
        chk("coin_t2_evt", 32'(evt_o), 32'h1);
        tick();
        chk("coin_t3_evt", 32'(evt_o), 32'h1);
        chk("coin_t3_busy", 32'(busy_o), 32'h1);
        tick();
        chk("coin_t4_evt", 32'(evt_o), 32'h0);
        chk("coin_t4_busy", 32'(busy_o), 32'h0);

        // Saturation on line 2: 3+3+3+3 pulses exceed the max of 7.
        region_evt_i = 12'h444;
        ticks(3);
        chk("sat_no_ovf_yet", 32'(evt_ovf_o), 32'h0);
        tick();
        chk("sat_ovf_set", 32'(evt_ovf_o), 32'h4);
        chk("sat_evt", 32'(evt_o), 32'h4);
        evt_ovf_clr_i = 1'b1;
        tick();
        chk("sat_set_wins", 32'(evt_ovf_o), 32'h4);
        region_evt_i = 12'h000;
        tick();
        evt_ovf_clr_i = 1'b0;
        chk("sat_cleared", 32'(evt_ovf_o), 32'h0);
        chk("sat_draining", 32'(evt_o), 32'h4);
        ticks(10);
        chk("sat_drained_evt", 32'(evt_o), 32'h0);
        chk("sat_drained_busy", 32'(busy_o), 32'h0);

        // test_mode overrides while gated.
        test_mode = 1'b1;
        cfg_req_i = 3'b101;
        #1;
        chk("tm_clk_en", 32'(region_clk_en_o), 32'h7);
        chk("tm_gnt_a", 32'(cfg_gnt_o), 32'h5);
        cfg_req_i = 3'b010;
        #1;
        chk("tm_gnt_b", 32'(cfg_gnt_o), 32'h2);
        tick();
        chk("tm_clk_en_hold", 32'(region_clk_en_o), 32'h7);
        tick();
        test_mode = 1'b0;
        cfg_req_i = 3'b000;
        #1;
        chk("tm_exit_clk_en", 32'(region_clk_en_o), 32'h7);
        chk("tm_exit_gnt", 32'(cfg_gnt_o), 32'h0);
        ticks(15);
        chk("tm_last_idle", 32'(region_clk_en_o), 32'h7);
        tick();
        chk("tm_gated", 32'(region_clk_en_o), 32'h0);

        // Reset mid-operation discards pending events.
        region_evt_i  = 12'h111;
        region_busy_i = 3'b010;
        tick();
        region_evt_i = 12'h000;
        chk("mid_pre_evt", 32'(evt_o), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_evt", 32'(evt_o), 32'h0);
        chk("mid_rst_busy", 32'(busy_o), 32'h0);
        chk("mid_rst_clk_en", 32'(region_clk_en_o), 32'h0);
        region_busy_i = 3'b000;
        tick();
        rst = 1'b0;
        ticks(3);
        chk("post_rst_evt", 32'(evt_o), 32'h0);
        chk("post_rst_busy", 32'(busy_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
